// File: rtl/tl_pkg.sv
// Shared types and constants for the tl_phase_arbiter intersection controller.
package tl_pkg;

  localparam int N_APPR = 4;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_AMBER  = 2'd2
  } tl_state_e;

  localparam logic [N_APPR-1:0] LAMP_ALL = 4'b1111;
  localparam logic [N_APPR-1:0] LAMP_OFF = 4'b0000;

  function automatic logic [N_APPR-1:0] lamp_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin approach picker: first requesting approach after `phase`,
// wrapping so that `phase` itself is the lowest priority.
module tl_rr_pick
  import tl_pkg::*;
(
  input  logic [N_APPR-1:0] req,
  input  logic [1:0]        phase,
  output logic [1:0]        pick,
  output logic              pick_valid
);

  logic [1:0] cand [N_APPR];

  generate
    for (genvar gi = 0; gi < N_APPR; gi++) begin : g_cand
      assign cand[gi] = phase + 2'(gi + 1);
    end
  endgenerate

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    pick = phase;
    for (int k = N_APPR - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        pick = cand[k];
      end
    end
  end

  assign pick_valid = |req;

endmodule

// File: rtl/tl_phase_arbiter.sv
// Four-approach traffic phase controller: round-robin green, amber, all-red.
// Define TL_PREEMPT_EN to add the preempt / preempt_dir override inputs.
module tl_phase_arbiter
  import tl_pkg::*;
#(
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int AMBER_T   = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_APPR-1:0] req,
`ifdef TL_PREEMPT_EN
  input  logic              preempt,
  input  logic [1:0]        preempt_dir,
`endif
  output logic [N_APPR-1:0] red,
  output logic [N_APPR-1:0] amber,
  output logic [N_APPR-1:0] green,
  output logic [1:0]        phase,
  output logic              new_green
);

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST  = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  tl_state_e         state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [1:0]        phase_q, phase_d;
  logic [N_APPR-1:0] red_q, red_d;
  logic [N_APPR-1:0] amber_q, amber_d;
  logic [N_APPR-1:0] green_q, green_d;
  logic              new_green_q, new_green_d;

  logic [1:0]        pick;
  logic              pick_valid;
  logic [N_APPR-1:0] others;
  logic              pre_active;
  logic [1:0]        pre_dir;

`ifdef TL_PREEMPT_EN
  assign pre_active = preempt;
  assign pre_dir    = preempt_dir;
`else
  assign pre_active = 1'b0;
  assign pre_dir    = 2'd0;
`endif

  tl_rr_pick u_pick (
    .req        (req),
    .phase      (phase_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  assign others = req & ~lamp_onehot(phase_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = (timer_q < MAX_LAST) ? timer_q + CNT_W'(1) : timer_q;

    case (state_q)
      ST_ALLRED: begin
        if (timer_q >= ALLRED_LAST) begin
          if (pre_active) begin
            state_d = ST_GREEN;
            phase_d = pre_dir;
          end else if (pick_valid) begin
            state_d = ST_GREEN;
            phase_d = pick;
          end
        end
      end
      ST_GREEN: begin
        // A preempting direction owns the decision; min green is bypassed.
        if (pre_active) begin
          if (pre_dir != phase_q) begin
            state_d = ST_AMBER;
          end
        end else if (timer_q >= MIN_LAST && others != LAMP_OFF &&
                     (!req[phase_q] || timer_q >= MAX_LAST)) begin
          state_d = ST_AMBER;
        end
      end
      ST_AMBER: begin
        if (timer_q >= AMBER_LAST) begin
          state_d = ST_ALLRED;
        end
      end
      default: state_d = ST_ALLRED;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end

    green_d     = (state_d == ST_GREEN) ? lamp_onehot(phase_d) : LAMP_OFF;
    amber_d     = (state_d == ST_AMBER) ? lamp_onehot(phase_d) : LAMP_OFF;
    red_d       = ~(green_d | amber_d);
    new_green_d = (state_d == ST_GREEN) && (state_q != ST_GREEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ALLRED;
      timer_q     <= '0;
      phase_q     <= 2'd3;
      red_q       <= LAMP_ALL;
      amber_q     <= LAMP_OFF;
      green_q     <= LAMP_OFF;
      new_green_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      red_q       <= red_d;
      amber_q     <= amber_d;
      green_q     <= green_d;
      new_green_q <= new_green_d;
    end
  end

  assign red       = red_q;
  assign amber     = amber_q;
  assign green     = green_q;
  assign phase     = phase_q;
  assign new_green = new_green_q;

endmodule

// File: doc/tl_phase_arbiter.md
Name: tl_phase_arbiter

Overview:
- Phase controller for a 4-approach intersection.
- Arbitrates green time between approaches using vehicle-demand sensors: round-robin grant, min/max green, then amber and all-red clearance between phases.
- Drives per-approach red/amber/green lamp outputs. Sits directly behind the sensor inputs in the top-level traffic controller.
- 1 clk tick = 1 s in the system; all timing parameters are in clk cycles.

Parameters:
MIN_GREEN, 10, minimum green cycles once granted
MAX_GREEN, 40, maximum green cycles while another approach is waiting (MAX_GREEN >= MIN_GREEN)
AMBER_T, 3, amber cycles
ALLRED_T, 2, all-red clearance cycles
CNT_W, 6, phase timer width (2^CNT_W > MAX_GREEN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req  in  4  per-approach demand, active-high, sampled every cycle
red  out  4  red lamp per approach
amber  out  4  amber lamp per approach
green  out  4  green lamp per approach
phase  out  2  index of current/last granted approach
new_green  out  1  one-cycle pulse on the first cycle of each green

Behaviour:
- Outputs are registered. Invariant every cycle: for each approach exactly one of red/amber/green is high, and at most one approach is non-red.
- Reset (async assert, mid-operation included):
  - state=ALLRED, timer=0, phase=3 (first search starts at 0).
  - red=4'b1111, amber=0, green=0, new_green=0.
- Timer: reset to 0 on every state entry; +1 per cycle; saturates at MAX_GREEN-1.
- Pick (combinational): first req bit set searching phase+1, phase+2, phase+3, then phase (mod 4). pick_valid = |req.
- ALLRED:
  - All lamps red.
  - When timer >= ALLRED_T-1 and pick_valid: next=GREEN, phase<=pick, new_green pulses with the first green cycle.
  - If no req: stay in ALLRED (rest in red) and evaluate every cycle.
- GREEN:
  - green[phase]=1, all others red.
  - Let others = req & ~onehot(phase).
  - Exit to AMBER when timer >= MIN_GREEN-1 and others!=0 and (req[phase]==0 or timer >= MAX_GREEN-1).
  - With no other demand, green rests indefinitely regardless of req[phase].
- AMBER: amber[phase]=1. After AMBER_T cycles, go to ALLRED. req is ignored.
- Resulting phase lengths:
  - Green: MIN_GREEN..MAX_GREEN cycles under contention.
  - Amber: exactly AMBER_T cycles.
  - All-red: exactly ALLRED_T cycles when demand is present.
- Only demand is the just-served approach: it is re-granted after the amber + all-red sequence (no shortcut).
- req changing during AMBER/ALLRED affects only the pick at the end of ALLRED.

Optional Feature:
- Macro: TL_PREEMPT_EN.
- With it defined:
  - Adds inputs preempt (1) and preempt_dir (2).
  - While preempt=1 in GREEN with phase!=preempt_dir: exit to AMBER on the next cycle, ignoring MIN_GREEN.
  - In GREEN with phase==preempt_dir: green is held (no exit).
  - At the end of ALLRED, preempt_dir is granted regardless of req and round-robin.
  - AMBER and ALLRED durations are never shortened.
- Without it: the ports do not exist and behaviour is exactly the base behaviour above.

Decomposition:
- Package tl_pkg:
  - State encoding ST_ALLRED=2'd0, ST_GREEN=2'd1, ST_AMBER=2'd2.
  - Approach count N_APPR=4.
  - Lamp-vector helper constants.
- One sub-module, tl_rr_pick (combinational): req[3:0], phase[1:0] -> pick[1:0], pick_valid.

Test Plan:
- Reset release with req=4'b0001 held: red=1111 for cycles 0-1; green=0001 from cycle 2 onward, held indefinitely; new_green high on cycle 2 only.
- As above, then req=4'b0101 from cycle 5: green[0] for cycles 2-41 (MAX_GREEN); amber[0] for 42-44; all red 45-46; green[2] from 47; phase=2.
- req=4'b0011 at reset, req[0] drops at cycle 4: green[0] lasts exactly 10 cycles (2-11); amber 12-14; red 15-16; green[1] at 17.
- req=4'b1111 constant: grant order 0,1,2,3,0; each green 40 cycles; each period 45 cycles; lamp invariant checked every cycle.
- reset driven low mid-AMBER (async, between edges): red=1111, amber=0, green=0 immediately, before the next clock edge. After release, the first green goes to the lowest requesting approach starting from 0.
- TL_PREEMPT_EN build: green[0] at timer=3, preempt=1 with preempt_dir=2: amber[0] next cycle for 3 cycles, then 2 all-red cycles, then green[2] even with req=0. green[2] holds while preempt=1.
